// File: rtl/wb_queue.sv
// Writeback queue: buffers execute-stage results and presents them to the
// register file in FIFO order, tracking which registers have queued writes.
module wb_queue #(
  parameter int NREG    = 16,
  parameter int REGNO_W = 4,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               res_valid,
  output logic               res_ready,
  input  logic [REGNO_W-1:0] res_regno,
  input  logic [DATA_W-1:0]  res_data,
  input  logic [NREG-1:0]    wb_reserved,
  input  logic               stall_wb,
  output logic               is_wb,
  output logic [REGNO_W-1:0] wb_regno,
  output logic [NREG-1:0]    wb_exp,
  output logic [DATA_W-1:0]  data_o,
  output logic [NREG-1:0]    pending,
  output logic               err_unreserved
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [REGNO_W-1:0] mem_regno [DEPTH];
  logic [DATA_W-1:0]  mem_data  [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic               err_q;
  logic               accept;
  logic               push;
  logic               pop;

  // Handshake: a result transfers on a rising edge with res_valid=1 and
  // res_ready=1; res_ready depends only on occupancy, never on this cycle's pop.
  assign res_ready = (count < CNT_W'(DEPTH));
  assign accept    = res_valid && res_ready;
  assign push      = accept && wb_reserved[res_regno];
  assign pop       = (count != '0) && !stall_wb;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (accept && !wb_reserved[res_regno]) err_q <= 1'b1;
    end
  end

  // Payload storage is not reset; occupancy alone qualifies every output.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_regno[wr_ptr] <= res_regno;
      mem_data[wr_ptr]  <= res_data;
    end
  end

  assign is_wb          = (count != '0);
  assign wb_regno       = is_wb ? mem_regno[rd_ptr] : '0;
  assign data_o         = is_wb ? mem_data[rd_ptr] : '0;
  assign wb_exp         = is_wb ? (NREG'(1) << wb_regno) : '0;
  assign err_unreserved = err_q;

  always_comb begin
    pending = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CNT_W'(k) < count) pending[mem_regno[rd_ptr + PTR_W'(k)]] = 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// Randomized and directed bench for wb_queue, checked every cycle against a
// queue-based model plus literal expectations for the directed scenarios.
module tb_wb_queue;

  localparam int NREG    = 16;
  localparam int REGNO_W = 4;
  localparam int DATA_W  = 32;
  localparam int DEPTH   = 4;

  logic               clk;
  logic               rst;
  logic               res_valid;
  logic               res_ready;
  logic [REGNO_W-1:0] res_regno;
  logic [DATA_W-1:0]  res_data;
  logic [NREG-1:0]    wb_reserved;
  logic               stall_wb;
  logic               is_wb;
  logic [REGNO_W-1:0] wb_regno;
  logic [NREG-1:0]    wb_exp;
  logic [DATA_W-1:0]  data_o;
  logic [NREG-1:0]    pending;
  logic               err_unreserved;

  int n_pass  = 0;
  int n_total = 0;

  wb_queue #(.NREG(NREG), .REGNO_W(REGNO_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .res_valid(res_valid), .res_ready(res_ready),
    .res_regno(res_regno), .res_data(res_data), .wb_reserved(wb_reserved),
    .stall_wb(stall_wb), .is_wb(is_wb), .wb_regno(wb_regno), .wb_exp(wb_exp),
    .data_o(data_o), .pending(pending), .err_unreserved(err_unreserved)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Each entry is {regno, data}; the queue order is the writeback order.
  logic [REGNO_W+DATA_W-1:0] exp_q[$];
  logic                      m_err;
  logic [REGNO_W+DATA_W-1:0] m_popped;
  int                        m_sz;

  initial m_err = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q.delete();
      m_err = 1'b0;
    end else begin
      m_sz = exp_q.size();
      if (m_sz > 0 && !stall_wb) m_popped = exp_q.pop_front();
      if (res_valid && m_sz < DEPTH) begin
        if (wb_reserved[res_regno]) exp_q.push_back({res_regno, res_data});
        else m_err = 1'b1;
      end
    end
  end

  // Compare process: outputs are registered, so the falling edge is stable.
  always @(negedge clk) begin
    logic [REGNO_W+DATA_W-1:0] head;
    logic [NREG-1:0]           e_pend;
    logic                      e_isw;
    e_isw  = (exp_q.size() > 0);
    head   = e_isw ? exp_q[0] : '0;
    e_pend = '0;
    foreach (exp_q[i]) e_pend[exp_q[i][REGNO_W+DATA_W-1:DATA_W]] = 1'b1;
    chk("res_ready", 64'(res_ready), 64'(exp_q.size() < DEPTH));
    chk("is_wb", 64'(is_wb), 64'(e_isw));
    chk("wb_regno", 64'(wb_regno), 64'(head[REGNO_W+DATA_W-1:DATA_W]));
    chk("data_o", 64'(data_o), 64'(head[DATA_W-1:0]));
    chk("wb_exp", 64'(wb_exp), e_isw ? 64'(NREG'(1) << head[REGNO_W+DATA_W-1:DATA_W]) : 64'(0));
    chk("pending", 64'(pending), 64'(e_pend));
    chk("err_unreserved", 64'(err_unreserved), 64'(m_err));
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    res_valid = 1'b0;
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic offer(input logic [REGNO_W-1:0] r, input logic [DATA_W-1:0] d);
    res_valid = 1'b1;
    res_regno = r;
    res_data  = d;
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [REGNO_W-1:0] order [4];
    order = '{4'd1, 4'd2, 4'd3, 4'd1};
    rst = 1'b0; res_valid = 1'b0; res_regno = '0; res_data = '0;
    wb_reserved = '0; stall_wb = 1'b0;

    // Reset values
    #1;
    chk("rst_ready", 64'(res_ready), 64'd1);
    chk("rst_is_wb", 64'(is_wb), 64'd0);
    chk("rst_pending", 64'(pending), 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // Single result, one-cycle latency, drained next edge
    wb_reserved = 16'h0004;
    offer(4'd2, 32'hDEADBEEF);
    res_valid = 1'b0;
    chk("s1_is_wb", 64'(is_wb), 64'd1);
    chk("s1_regno", 64'(wb_regno), 64'd2);
    chk("s1_exp", 64'(wb_exp), 64'h0004);
    chk("s1_data", 64'(data_o), 64'hDEADBEEF);
    chk("s1_pending", 64'(pending), 64'h0004);
    @(negedge clk);
    chk("s1_empty", 64'(is_wb), 64'd0);

    // Fill while stalled, then drain in order
    wb_reserved = 16'hFFFF;
    stall_wb = 1'b1;
    for (int i = 0; i < 4; i++) offer(order[i], 32'h100 + 32'(i));
    res_valid = 1'b0;
    chk("s2_ready_full", 64'(res_ready), 64'd0);
    chk("s2_pending", 64'(pending), 64'h000E);
    @(negedge clk);
    chk("s2_hold_regno", 64'(wb_regno), 64'd1);
    stall_wb = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("s2_order", 64'(wb_regno), 64'(order[i]));
      @(negedge clk);
    end
    chk("s2_drained", 64'(is_wb), 64'd0);

    // Full queue with valid held: one blocked cycle, then push+pop together
    stall_wb = 1'b1;
    for (int i = 0; i < 4; i++) offer(4'(4 + i), 32'h200 + 32'(i));
    stall_wb = 1'b0;
    res_valid = 1'b1; res_regno = 4'd8; res_data = 32'h0000_0208;
    chk("s3_ready_full", 64'(res_ready), 64'd0);
    @(negedge clk);
    chk("s3_ready_after_pop", 64'(res_ready), 64'd1);
    chk("s3_head", 64'(wb_regno), 64'd5);
    @(negedge clk);
    chk("s3_ready_pushpop", 64'(res_ready), 64'd1);
    chk("s3_head2", 64'(wb_regno), 64'd6);
    idle(6);

    // Unreserved register: discarded, sticky error
    wb_reserved = 16'hFFDF;
    offer(4'd5, 32'hBAD0_0005);
    res_valid = 1'b0;
    chk("s4_err", 64'(err_unreserved), 64'd1);
    chk("s4_no_wb", 64'(is_wb), 64'd0);
    idle(10);
    chk("s4_err_sticky", 64'(err_unreserved), 64'd1);

    // Asynchronous reset with three entries queued
    stall_wb = 1'b1;
    wb_reserved = 16'hFFFF;
    for (int i = 0; i < 3; i++) offer(4'(10 + i), 32'h300 + 32'(i));
    res_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("s5_is_wb", 64'(is_wb), 64'd0);
    chk("s5_pending", 64'(pending), 64'd0);
    chk("s5_err", 64'(err_unreserved), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    stall_wb = 1'b0;
    @(negedge clk);
    chk("s5_empty", 64'(is_wb), 64'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 1000; c++) begin
      res_valid   = ($urandom_range(0, 99) < 60);
      stall_wb    = ($urandom_range(0, 99) < 35);
      res_regno   = REGNO_W'($urandom_range(0, NREG - 1));
      res_data    = $urandom;
      wb_reserved = ($urandom_range(0, 19) == 0) ? NREG'($urandom) : '1;
      @(negedge clk);
    end
    stall_wb = 1'b0;
    idle(8);
    chk("final_empty", 64'(is_wb), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
